uart7n_tx_arbiter: RTL
======================

// Module: uart7n_tx_arbiter
// PURPOSE
//   Shares one uart7n_top transmitter among p_num_req requesters using round-robin arbitration.
//   Captures the winner's byte, launches one TX frame, and waits for the UART to report completion.
//   Returns per-requester ack and done pulses.
//   Sits between the application clients and the TX-side ports of uart7n_top
//   (data_tx_i, enable_tx_i, tx_busy_o, tx_data_sent_o).
// PARAMETERS
//   p_num_req        4        number of requesters, 2..8
//   p_data_w         8        frame payload width (matches uart7n_top data_tx_i)
//   p_timeout_cycles 100_000  clk_i cycles allowed for completion; used only with UART7N_TX_ARB_TIMEOUT_EN
// PORTS
//   clk_i            in   1                  system clock
//   rst_i            in   1                  reset, asynchronous, active-high
//   req_i            in   p_num_req          per-requester request level; held until matching ack_o
//   data_i           in   p_num_req*p_data_w packed bytes; requester k at [k*p_data_w +: p_data_w]
//   ack_o            out  p_num_req          1-cycle pulse: byte captured, requester may drop req_i
//   done_o           out  p_num_req          1-cycle pulse: frame for that requester finished
//   err_o            out  1                  1-cycle pulse: frame aborted by timeout (macro only, else tied 0)
//   busy_o           out  1                  high whenever FSM is not IDLE
//   grant_id_o       out  3                  index of current/last granted requester
//   tx_data_o        out  p_data_w           to uart7n_top data_tx_i; stable from LAUNCH until IDLE
//   tx_enable_o      out  1                  to uart7n_top enable_tx_i; exactly 1-cycle pulse per frame
//   tx_busy_i        in   1                  from uart7n_top tx_busy_o
//   tx_data_sent_i   in   1                  from uart7n_top tx_data_sent_o (level; rising edge = completion)
// BEHAVIOUR
//   Reset
//   - Outputs in reset: ack_o=0, done_o=0, err_o=0, busy_o=0, grant_id_o=0, tx_data_o=0, tx_enable_o=0.
//   - Internal state in reset: rr pointer=0, state=IDLE, sent_q=0.
//   - rst_i asserted mid-frame aborts immediately to IDLE. No done_o or err_o is issued.
//     The UART is not reset by this block.
//   FSM: IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_SENT -> IDLE
//   - IDLE: if any req_i, pick the first set bit at or after the rr pointer (wrapping modulo p_num_req).
//     Register grant_id_o and tx_data_o. Go to LAUNCH.
//   - LAUNCH (1 cycle): tx_enable_o=1 and ack_o[grant]=1. Go to WAIT_BUSY.
//     Set rr pointer to grant+1, wrapping at p_num_req-1 -> 0.
//   - WAIT_BUSY: on tx_busy_i=1, go to WAIT_SENT.
//     A tx_data_sent_i rising edge seen here also completes the frame (short-frame case).
//   - WAIT_SENT: on tx_data_sent_i rising edge (sent_q registers the prior value), pulse done_o[grant] and go to IDLE.
//   Timing and protocol rules
//   - Latency: req_i sampled high at edge t gives ack_o and tx_enable_o during cycle t+1.
//   - Back-to-back: the next arbitration happens in the IDLE cycle after done_o, so frames are separated by at least 1 idle cycle.
//   - Requests arriving while busy_o=1 wait; they are never lost while held.
//   - req_i dropped before ack_o is a protocol violation. If dropped while in IDLE, the request is simply not granted.
//   - Only one requester is ever acknowledged per frame. Simultaneous requests are resolved purely by the rr pointer.
// CONFIGURATION
//   UART7N_TX_ARB_TIMEOUT_EN defined:
//   - A counter runs in WAIT_BUSY and WAIT_SENT. It is cleared on entry to LAUNCH.
//   - When it reaches p_timeout_cycles-1, pulse err_o and done_o[grant] together and go to IDLE.
//   - The rr pointer is already advanced at that point.
//   UART7N_TX_ARB_TIMEOUT_EN undefined:
//   - No counter. err_o is tied to 0. The FSM waits indefinitely for completion.
// STRUCTURE
//   uart7n_pkg (shared): FSM state encoding localparams/enum, clog2 helper, default p_data_w.
//   Sub-module uart7n_rr_picker: combinational round-robin picker.
//   - Inputs: req vector, pointer. Outputs: grant index, any_req.
//   - Reusable for a future RX-side dispatcher.
// TESTING
//   1. Single request: req_i=4'b0100, data[2]=8'h53.
//      -> ack_o[2] and tx_enable_o one cycle later, tx_data_o=8'h53.
//      -> After busy then sent edge: done_o=4'b0100, busy_o=0.
//   2. All requesters held: req_i=4'b1111 with distinct bytes 8'hA0..8'hA3.
//      -> grants in order 0,1,2,3,0. Each tx_enable_o is a single cycle. Exactly one ack per frame.
//   3. Pointer wrap: rr pointer=3, req_i=4'b1001.
//      -> grant 3, then grant 0. A request set only on bit 3 afterwards is granted again (no starvation).
//   4. rst_i asserted in WAIT_SENT.
//      -> all outputs 0 asynchronously. No done_o. Pending req_i is re-arbitrated from pointer 0 after release.
//   5. Short frame: tx_data_sent_i rises while tx_busy_i never seen high.
//      -> done_o pulses, FSM returns to IDLE.
//   6. Macro on, p_timeout_cycles=16, tx_busy_i held 0.
//      -> err_o and done_o[grant] pulse 16 cycles after LAUNCH. Next requester served.
//      Macro off: FSM stays in WAIT_BUSY.

Source files
------------

// File: rtl/uart7n_pkg.sv
// Shared definitions for the uart7n TX-side arbiter and its picker.
// FSM encoding, default payload width and a constant clog2 helper.
package uart7n_pkg;

    localparam int unsigned C_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_SENT = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart7n_tx_arbiter_if.sv
// Client and UART-TX side bundle of the uart7n TX arbiter.
// slave = arbiter view, master = clients plus UART view.
interface uart7n_tx_arbiter_if
    import uart7n_pkg::*;
#(
    parameter int unsigned p_num_req = 4,
    parameter int unsigned p_data_w  = C_DATA_W
);
    logic [p_num_req-1:0]          req_i;
    logic [p_num_req*p_data_w-1:0] data_i;
    logic [p_num_req-1:0]          ack_o;
    logic [p_num_req-1:0]          done_o;
    logic                          err_o;
    logic                          busy_o;
    logic [2:0]                    grant_id_o;
    logic [p_data_w-1:0]           tx_data_o;
    logic                          tx_enable_o;
    logic                          tx_busy_i;
    logic                          tx_data_sent_i;

    modport slave (
        input  req_i, data_i, tx_busy_i, tx_data_sent_i,
        output ack_o, done_o, err_o, busy_o, grant_id_o,
        output tx_data_o, tx_enable_o
    );

    modport master (
        output req_i, data_i, tx_busy_i, tx_data_sent_i,
        input  ack_o, done_o, err_o, busy_o, grant_id_o,
        input  tx_data_o, tx_enable_o
    );
endinterface

// File: rtl/uart7n_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr.
// Wraps modulo p_num_req; grant is 0 when nothing is requested.
module uart7n_rr_picker
    import uart7n_pkg::*;
#(
    parameter int unsigned p_num_req = 4,
    localparam int unsigned c_idx_w = clog2(p_num_req)
) (
    input  logic [p_num_req-1:0] req_i,
    input  logic [c_idx_w-1:0]   ptr_i,
    output logic [c_idx_w-1:0]   grant_o,
    output logic                 any_o
);

    // Scan offsets from far to near so the nearest request wins.
    always_comb begin
        int unsigned j;
        logic [c_idx_w-1:0] idx;
        grant_o = '0;
        any_o   = |req_i;
        j       = 0;
        idx     = '0;
        for (int i = int'(p_num_req) - 1; i >= 0; i--) begin
            j = int'(ptr_i) + i;
            if (j >= p_num_req) begin
                j = j - p_num_req;
            end
            idx = c_idx_w'(j);
            if (req_i[idx]) begin
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/uart7n_tx_arbiter.sv
// Round-robin sharing of one uart7n transmitter among p_num_req clients.
// Optional completion timeout: define UART7N_TX_ARB_TIMEOUT_EN.
module uart7n_tx_arbiter
    import uart7n_pkg::*;
#(
    parameter int unsigned p_num_req        = 4,
    parameter int unsigned p_data_w         = C_DATA_W,
    parameter int unsigned p_timeout_cycles = 100_000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    uart7n_tx_arbiter_if.slave bus
);

    localparam int unsigned c_idx_w = clog2(p_num_req);
    localparam logic [p_num_req-1:0] c_one = 1;

    state_t               state_q, state_d;
    logic [c_idx_w-1:0]   ptr_q, ptr_d;
    logic [c_idx_w-1:0]   grant_q, grant_d;
    logic [p_data_w-1:0]  data_q, data_d;
    logic [p_num_req-1:0] done_q, done_d;
    logic                 err_q, err_d;
    logic                 sent_q;

    logic [c_idx_w-1:0]   pick;
    logic                 any_req;
    logic                 sent_rise;
    logic                 timeout;
    logic [p_data_w-1:0]  bytes_w [p_num_req];

    for (genvar k = 0; k < p_num_req; k++) begin : g_bytes
        assign bytes_w[k] = bus.data_i[k*p_data_w +: p_data_w];
    end

    uart7n_rr_picker #(
        .p_num_req(p_num_req)
    ) u_picker (
        .req_i  (bus.req_i),
        .ptr_i  (ptr_q),
        .grant_o(pick),
        .any_o  (any_req)
    );

    assign sent_rise = bus.tx_data_sent_i & ~sent_q;

`ifdef UART7N_TX_ARB_TIMEOUT_EN
    localparam int unsigned c_cnt_w = clog2(p_timeout_cycles);

    logic [c_cnt_w-1:0] cnt_q;

    assign timeout = (state_q == S_WAIT_BUSY || state_q == S_WAIT_SENT)
                   && (cnt_q == c_cnt_w'(p_timeout_cycles - 1));

    // Cycle counter since launch; restarted on every new grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + c_cnt_w'(1);
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = (p_timeout_cycles == 0);
`endif

    // State, pointer and captured-frame registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sent_q  <= bus.tx_data_sent_i;
        end
    end

    // Next-state, capture and completion decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        done_d  = '0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    data_d  = bytes_w[pick];
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (grant_q == c_idx_w'(p_num_req - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_q + c_idx_w'(1);
                end
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (sent_rise) begin
                    done_d  = c_one << grant_q;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    done_d  = c_one << grant_q;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.tx_busy_i) begin
                    state_d = S_WAIT_SENT;
                end
            end
            S_WAIT_SENT: begin
                if (sent_rise) begin
                    done_d  = c_one << grant_q;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    done_d  = c_one << grant_q;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.tx_enable_o = (state_q == S_LAUNCH);
    assign bus.ack_o       = (state_q == S_LAUNCH) ? (c_one << grant_q) : '0;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.grant_id_o  = 3'(grant_q);
    assign bus.tx_data_o   = data_q;

endmodule
